// File: rtl/seq_pkg.sv
// Shared definitions for the stage sequencer: FSM state encodings and a clog2 helper.
package seq_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SRST = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/next_stage_find.sv
// Finds the lowest enabled stage above i_cur (or at i_cur when i_incl is set,
// which turns it into the first-stage search).
module next_stage_find
  import seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3
) (
  input  logic [NUM_STAGES-1:0] i_en,
  input  logic [2:0]            i_cur,
  input  logic                  i_incl,
  output logic                  o_found,
  output logic [2:0]            o_next
);

  always_comb begin
    o_found = 1'b0;
    o_next  = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (!o_found && i_en[i] &&
          ((3'(i) > i_cur) || (i_incl && (3'(i) == i_cur)))) begin
        o_found = 1'b1;
        o_next  = 3'(i);
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Runs NUM_STAGES engines in order: per-stage reset pulse, chip-select and a
// zero-latency mux of the active stage onto the shared memory bus.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LEN_W      = 10,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_STAGES-1:0]        stage_en,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0] stg_addr,
  input  logic [NUM_STAGES*ADDR_W-1:0] stg_addr1,
  input  logic [NUM_STAGES*DATA_W-1:0] stg_wdata,
  input  logic [NUM_STAGES-1:0]        stg_wen,
  input  logic [NUM_STAGES-1:0]        stg_ren,
  input  logic [LEN_W-1:0]             len_in,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [ADDR_W-1:0]            mem_addr1,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_wen,
  output logic                         mem_ren,
  output logic [DATA_W-1:0]            stg_rdata,
  output logic [NUM_STAGES-1:0]        cs,
  output logic [NUM_STAGES-1:0]        stage_rst,
  output logic [LEN_W-1:0]             len_out,
  output logic [2:0]                   cur_stage,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int unsigned TW = (clog2(TIMEOUT + 1) == 0) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [2:0]            r_state;
  logic [2:0]            r_cur;
  logic [NUM_STAGES-1:0] r_en;
  logic [TW-1:0]         r_timer;
  logic [LEN_W-1:0]      r_len;
  logic                  r_error;

  logic                  w_idle;
  logic [NUM_STAGES-1:0] w_sel;
  logic [NUM_STAGES-1:0] w_srch_en;
  logic [2:0]            w_srch_cur;
  logic                  w_found;
  logic [2:0]            w_next;
  logic                  w_active_done;

  assign w_idle        = (r_state == S_IDLE);
  assign w_sel         = NUM_STAGES'(1) << r_cur;
  assign w_active_done = |(stage_done & w_sel);

  // In IDLE the search runs over the live mask from stage 0 inclusive.
  assign w_srch_en  = w_idle ? stage_en : r_en;
  assign w_srch_cur = w_idle ? 3'd0 : r_cur;

  next_stage_find #(.NUM_STAGES(NUM_STAGES)) u_find (
    .i_en    (w_srch_en),
    .i_cur   (w_srch_cur),
    .i_incl  (w_idle),
    .o_found (w_found),
    .o_next  (w_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_en    <= '0;
      r_timer <= '0;
      r_len   <= '0;
      r_error <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_en    <= stage_en;
            r_error <= 1'b0;
            if (w_found) begin
              r_cur   <= w_next;
              r_state <= S_SRST;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_SRST: begin
          r_timer <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_timer != '1) r_timer <= r_timer + TW'(1);
          if (w_active_done) begin
            if (r_cur == 3'd0) r_len <= len_in;
            if (w_found) begin
              r_cur   <= w_next;
              r_state <= S_SRST;
            end else begin
              r_state <= S_DONE;
            end
          end else if ((TIMEOUT != 0) && (r_timer == T_LAST)) begin
            r_state <= S_ERR;
          end
        end
        S_DONE: r_state <= S_IDLE;
        S_ERR: begin
          r_error <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cs        = (r_state == S_RUN)  ? w_sel : '0;
  assign stage_rst = (r_state == S_SRST) ? w_sel : '0;
  assign busy      = !w_idle;
  assign done      = (r_state == S_DONE);
  assign error     = r_error;
  assign len_out   = r_len;
  assign cur_stage = r_cur;
  assign stg_rdata = mem_rdata;

  always_comb begin
    mem_addr  = '0;
    mem_addr1 = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (r_state == S_RUN) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        if (w_sel[i]) begin
          mem_addr  = stg_addr[i*ADDR_W +: ADDR_W];
          mem_addr1 = stg_addr1[i*ADDR_W +: ADDR_W];
          mem_wdata = stg_wdata[i*DATA_W +: DATA_W];
          mem_wen   = stg_wen[i];
          mem_ren   = stg_ren[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: scenario schedules are expanded into per-cycle
// expected outputs, compared every cycle, plus hand-computed literal pins.
module tb_stage_sequencer;

  localparam int unsigned NS = 3, DW = 8, AW = 10, LW = 10, TO = 16, MAXC = 64;
  localparam logic [9:0] JUNK = 10'h155;
  localparam logic [9:0] PA [3] = '{10'h0AA, 10'h155, 10'h3FF};
  localparam logic [9:0] PB [3] = '{10'h333, 10'h222, 10'h111};
  localparam logic [7:0] PD [3] = '{8'hA5, 8'h5A, 8'hC3};
  localparam logic [2:0] PW = 3'b101;
  localparam logic [2:0] PR = 3'b011;

  logic clk = 1'b0;
  logic reset, start, abort;
  logic [NS-1:0] stage_en, stage_done, stg_wen, stg_ren, cs, stage_rst;
  logic [NS*AW-1:0] stg_addr, stg_addr1;
  logic [NS*DW-1:0] stg_wdata;
  logic [LW-1:0] len_in, len_out;
  logic [DW-1:0] mem_rdata, mem_wdata, stg_rdata;
  logic [AW-1:0] mem_addr, mem_addr1;
  logic mem_wen, mem_ren, busy, done, error;
  logic [2:0] cur_stage;

  stage_sequencer #(.NUM_STAGES(NS), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .stage_en(stage_en),
    .stage_done(stage_done), .stg_addr(stg_addr), .stg_addr1(stg_addr1), .stg_wdata(stg_wdata),
    .stg_wen(stg_wen), .stg_ren(stg_ren), .len_in(len_in), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_addr1(mem_addr1), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .stg_rdata(stg_rdata), .cs(cs), .stage_rst(stage_rst), .len_out(len_out),
    .cur_stage(cur_stage), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle schedule: stimulus and expected outputs.
  int n;
  logic [2:0] cur_mask;
  logic       s_start [MAXC], s_abort [MAXC];
  logic [2:0] s_en [MAXC], s_done [MAXC];
  logic [9:0] s_len [MAXC];
  logic [2:0] e_cs [MAXC], e_rst [MAXC], e_cur [MAXC];
  logic       e_busy [MAXC], e_done [MAXC], e_err [MAXC];
  logic [9:0] e_len [MAXC];
  int         e_act [MAXC];

  logic [2:0] m_cur = '0;
  logic       m_err = 1'b0;
  logic [9:0] m_len = '0;

  task automatic add_cycle(input logic [2:0] cs_x, input logic [2:0] rst_x, input logic busy_x,
                           input logic done_x, input int act, input logic [2:0] sd,
                           input logic st, input logic ab, input logic [9:0] lv);
    s_start[n] = st;  s_abort[n] = ab;  s_done[n] = sd;  s_len[n] = lv;
    s_en[n]    = (n == 0) ? cur_mask : ~cur_mask;
    e_cs[n]    = cs_x; e_rst[n] = rst_x; e_busy[n] = busy_x; e_done[n] = done_x;
    e_act[n]   = act;  e_cur[n] = m_cur; e_err[n]  = m_err;  e_len[n]  = m_len;
    n++;
  endtask

  // Stages run in ascending order of set mask bits: 1 reset cycle, then rl RUN
  // cycles with done on the last one (or TO cycles and an error cycle on to_stage).
  task automatic build(input logic [2:0] mask, input int rl, input int to_stage, input int ab_stage,
                       input logic [9:0] lv, input logic [2:0] noise, input logic busy_start);
    logic [2:0] b;
    logic       last;
    n = 0;
    cur_mask = mask;
    add_cycle(3'b0, 3'b0, 1'b0, 1'b0, -1, 3'b0, 1'b1, 1'b0, JUNK);
    m_err = 1'b0;
    if (mask == 3'b0) begin
      add_cycle(3'b0, 3'b0, 1'b1, 1'b1, -1, 3'b0, busy_start, 1'b0, JUNK);
      add_cycle(3'b0, 3'b0, 1'b0, 1'b0, -1, 3'b0, 1'b0, 1'b0, JUNK);
      return;
    end
    for (int s = 0; s < int'(NS); s++) begin
      if (!mask[s]) continue;
      m_cur = 3'(s);
      b = 3'b001 << s;
      add_cycle(3'b0, b, 1'b1, 1'b0, -1, noise & ~b, busy_start, 1'b0, JUNK);
      if (s == to_stage) begin
        for (int r = 0; r < int'(TO); r++)
          add_cycle(b, 3'b0, 1'b1, 1'b0, s, noise & ~b, busy_start, 1'b0, JUNK);
        add_cycle(3'b0, 3'b0, 1'b1, 1'b0, -1, 3'b0, busy_start, 1'b0, JUNK);
        m_err = 1'b1;
        add_cycle(3'b0, 3'b0, 1'b0, 1'b0, -1, 3'b0, 1'b0, 1'b0, JUNK);
        return;
      end
      for (int r = 0; r < rl; r++) begin
        last = (r == rl - 1);
        add_cycle(b, 3'b0, 1'b1, 1'b0, s, (noise & ~b) | (last ? b : 3'b0), busy_start,
                  last && (s == ab_stage), (last && s == 0) ? lv : JUNK);
        if (last && s == ab_stage) begin
          add_cycle(3'b0, 3'b0, 1'b0, 1'b0, -1, 3'b0, 1'b0, 1'b0, JUNK);
          return;
        end
        if (last && s == 0) m_len = lv;
      end
    end
    add_cycle(3'b0, 3'b0, 1'b1, 1'b1, -1, 3'b0, busy_start, 1'b0, JUNK);
    add_cycle(3'b0, 3'b0, 1'b0, 1'b0, -1, 3'b0, 1'b0, 1'b0, JUNK);
  endtask

  // Compare process and observation log.
  logic chk_on = 1'b0;
  int cur_k = 0, done_cnt, done_k, err_k, ck;
  logic [2:0] rst_q [$];
  logic [2:0] cs_or;
  logic [9:0] last_a2, xa, xb;
  logic       last_w2, xw, xr;
  logic [7:0] xd;

  always @(negedge clk) begin
    if (chk_on) begin
      ck = cur_k;
      check("cs", cs, e_cs[ck]);
      check("stage_rst", stage_rst, e_rst[ck]);
      check("busy", busy, e_busy[ck]);
      check("done", done, e_done[ck]);
      check("error", error, e_err[ck]);
      check("cur_stage", cur_stage, e_cur[ck]);
      check("len_out", len_out, e_len[ck]);
      if (e_act[ck] >= 0) begin
        xa = PA[e_act[ck]]; xb = PB[e_act[ck]]; xd = PD[e_act[ck]];
        xw = PW[e_act[ck]]; xr = PR[e_act[ck]];
      end else begin
        xa = '0; xb = '0; xd = '0; xw = 1'b0; xr = 1'b0;
      end
      check("mem_addr", mem_addr, xa);
      check("mem_addr1", mem_addr1, xb);
      check("mem_wdata", mem_wdata, xd);
      check("mem_wen", mem_wen, xw);
      check("mem_ren", mem_ren, xr);
      check("stg_rdata", stg_rdata, mem_rdata);
      if (done) begin done_cnt++; done_k = ck; end
      if (error && err_k < 0) err_k = ck;
      if (stage_rst != 3'b0) rst_q.push_back(stage_rst);
      cs_or = cs_or | cs;
      if (cs == 3'b100) begin last_a2 = mem_addr; last_w2 = mem_wen; end
    end
  end

  task automatic run_scn();
    done_cnt = 0; done_k = -1; err_k = -1; cs_or = '0; rst_q.delete();
    last_a2 = '0; last_w2 = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start = s_start[k]; abort = s_abort[k]; stage_en = s_en[k];
      stage_done = s_done[k]; len_in = s_len[k]; mem_rdata = 8'(k * 7 + 3);
      cur_k = k; chk_on = 1'b1;
    end
    @(posedge clk); #1;
    chk_on = 1'b0; start = 1'b0; abort = 1'b0; stage_done = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b1; abort = 1'b0; stage_en = '1; stage_done = '1;
    stg_addr = {PA[2], PA[1], PA[0]}; stg_addr1 = {PB[2], PB[1], PB[0]};
    stg_wdata = {PD[2], PD[1], PD[0]}; stg_wen = '1; stg_ren = '1;
    len_in = JUNK; mem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", cs, 3'b0);
    check("rst_stage_rst", stage_rst, 3'b0);
    check("rst_mem_wen", mem_wen, 1'b0);
    check("rst_mem_ren", mem_ren, 1'b0);
    check("rst_mem_addr", mem_addr, 10'h0);
    check("rst_mem_addr1", mem_addr1, 10'h0);
    check("rst_mem_wdata", mem_wdata, 8'h0);
    check("rst_len_out", len_out, 10'h0);
    check("rst_cur_stage", cur_stage, 3'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    reset = 1'b1; start = 1'b0; stage_done = '0; stg_wen = PW; stg_ren = PR;

    // All three stages, done 5 cycles after cs; len 37 from stage 0.
    build(3'b111, 6, -1, -1, 10'd37, 3'b000, 1'b0);
    run_scn();
    check("A_done_cnt", done_cnt, 1);
    check("A_done_cycle", done_k, 22);
    check("A_rst_cnt", rst_q.size(), 3);
    check("A_rst0", rst_q[0], 3'b001);
    check("A_rst1", rst_q[1], 3'b010);
    check("A_rst2", rst_q[2], 3'b100);
    check("A_len", len_out, 10'd37);

    // Skip stage 1; spurious done on idle stages, start held while busy.
    build(3'b101, 3, -1, -1, 10'd12, 3'b111, 1'b1);
    run_scn();
    check("B_rst_cnt", rst_q.size(), 2);
    check("B_rst0", rst_q[0], 3'b001);
    check("B_rst1", rst_q[1], 3'b100);
    check("B_cs_seen", cs_or, 3'b101);
    check("B_done_cnt", done_cnt, 1);
    check("B_done_cycle", done_k, 9);

    // Stage 1 never finishes: timeout after 16 RUN cycles.
    build(3'b111, 6, 1, -1, 10'd99, 3'b000, 1'b0);
    run_scn();
    check("C_err_cycle", err_k, 26);
    check("C_done_cnt", done_cnt, 0);
    check("C_error", error, 1'b1);

    // abort and start together in IDLE: nothing starts, error held.
    n = 0; cur_mask = 3'b111;
    add_cycle(3'b0, 3'b0, 1'b0, 1'b0, -1, 3'b0, 1'b1, 1'b1, JUNK);
    add_cycle(3'b0, 3'b0, 1'b0, 1'b0, -1, 3'b0, 1'b0, 1'b0, JUNK);
    run_scn();
    check("AB_error_held", error, 1'b1);
    check("AB_rst_cnt", rst_q.size(), 0);

    // abort coincides with stage 2 done: no done pulse, len kept.
    build(3'b111, 2, -1, 2, 10'd5, 3'b000, 1'b0);
    run_scn();
    check("D_done_cnt", done_cnt, 0);
    check("D_len", len_out, 10'd5);
    check("D_error_cleared", error, 1'b0);

    // Empty mask: done pulse straight after start.
    build(3'b000, 1, -1, -1, 10'd0, 3'b000, 1'b0);
    run_scn();
    check("E_done_cycle", done_k, 1);
    check("E_done_cnt", done_cnt, 1);

    // Stage 2 alone: its 3FF address and write enable appear on the bus.
    build(3'b100, 4, -1, -1, 10'd0, 3'b000, 1'b0);
    run_scn();
    check("F_addr", last_a2, 10'h3FF);
    check("F_wen", last_w2, 1'b1);
    stg_wen = '1; stg_ren = '1;
    #1;
    check("F_idle_wen", mem_wen, 1'b0);
    check("F_idle_ren", mem_ren, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
